// File: rtl/field_sweep_sched.sv
// Serpentine field-sweep sequencer for the weed-robot drive.
// Walks NUM_ROWS rows of ROW_LEN forward steps. It turns right at the end of
// even rows and left at the end of odd rows. When a plant is seen it halts
// and hands off to the sprayer through a req/done handshake.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start               begin a sweep (sampled in IDLE and DONE only)
//   plant               plant detected (level)
//   spray_done          sprayer acknowledge
//   front/right/left    one-cycle motion command pulses
//   stop, spray_req     halt / spray request levels
//   busy, done, fault   status (fault is sticky until reset)
//   row_idx, col_idx    current row and forward steps taken in that row
module field_sweep_sched #(
    parameter logic [23:0] STEP_CYCLES   = 24'd15_000_000,
    parameter logic [7:0]  ROW_LEN       = 8'd4,
    parameter logic [7:0]  NUM_ROWS      = 8'd6,
    parameter logic [23:0] SPRAY_TIMEOUT = 24'd1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       plant,
    input  logic       spray_done,
    output logic       front,
    output logic       right,
    output logic       left,
    output logic       stop,
    output logic       spray_req,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [7:0] row_idx,
    output logic [7:0] col_idx
);

    localparam int unsigned TIMER_W = 24;
    localparam int unsigned IDX_W   = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP  = 3'd1,
        SPRAY = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t             state, state_d;
    logic [TIMER_W-1:0] step_cnt, step_cnt_d;
    logic [TIMER_W-1:0] spray_cnt, spray_cnt_d;
    logic [IDX_W-1:0]   row_d, col_d;
    logic               front_d, right_d, left_d;
    logic               stop_d, spray_req_d, busy_d, done_d, fault_d;

    // State, counters and every output are registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            step_cnt  <= '0;
            spray_cnt <= '0;
            row_idx   <= '0;
            col_idx   <= '0;
            front     <= 1'b0;
            right     <= 1'b0;
            left      <= 1'b0;
            stop      <= 1'b0;
            spray_req <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_d;
            step_cnt  <= step_cnt_d;
            spray_cnt <= spray_cnt_d;
            row_idx   <= row_d;
            col_idx   <= col_d;
            front     <= front_d;
            right     <= right_d;
            left      <= left_d;
            stop      <= stop_d;
            spray_req <= spray_req_d;
            busy      <= busy_d;
            done      <= done_d;
            fault     <= fault_d;
        end
    end

    // Next state, counters and command pulses.
    always_comb begin
        state_d     = state;
        step_cnt_d  = step_cnt;
        spray_cnt_d = spray_cnt;
        row_d       = row_idx;
        col_d       = col_idx;
        front_d     = 1'b0;
        right_d     = 1'b0;
        left_d      = 1'b0;

        case (state)
            IDLE: begin
                step_cnt_d  = '0;
                spray_cnt_d = '0;
                row_d       = '0;
                col_d       = '0;
                if (start) state_d = STEP;
            end
            STEP: begin
                // A plant pre-empts any tick that lands on the same cycle.
                if (plant) begin
                    state_d     = SPRAY;
                    step_cnt_d  = '0;
                    spray_cnt_d = '0;
                end else if (step_cnt == STEP_CYCLES - TIMER_W'(1)) begin
                    step_cnt_d = '0;
                    if (col_idx < ROW_LEN) begin
                        front_d = 1'b1;
                        col_d   = col_idx + IDX_W'(1);
                    end else if (row_idx == NUM_ROWS - IDX_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        // Even rows turn right, odd rows turn left.
                        right_d = ~row_idx[0];
                        left_d  = row_idx[0];
                        row_d   = row_idx + IDX_W'(1);
                        col_d   = '0;
                    end
                end else begin
                    step_cnt_d = step_cnt + TIMER_W'(1);
                end
            end
            SPRAY: begin
                if (spray_done) begin
                    state_d     = STEP;
                    step_cnt_d  = '0;
                    spray_cnt_d = '0;
                end else if (spray_cnt == SPRAY_TIMEOUT - TIMER_W'(1)) begin
                    state_d = FAULT;
                end else begin
                    spray_cnt_d = spray_cnt + TIMER_W'(1);
                end
            end
            DONE: begin
                if (start) begin
                    state_d    = STEP;
                    step_cnt_d = '0;
                    row_d      = '0;
                    col_d      = '0;
                end
            end
            FAULT: begin
                // Only reset leaves FAULT.
            end
            default: state_d = IDLE;
        endcase
    end

    // Status levels follow the state being entered so they are registered with it.
    always_comb begin
        stop_d      = (state_d == SPRAY) || (state_d == FAULT);
        spray_req_d = (state_d == SPRAY);
        busy_d      = (state_d == STEP) || (state_d == SPRAY);
        done_d      = (state_d == DONE);
        fault_d     = (state_d == FAULT);
    end

endmodule

// File: tb/tb_field_sweep_sched.sv
module tb_field_sweep_sched;

    localparam logic [23:0] SC = 24'd4;
    localparam logic [7:0]  RL = 8'd3;
    localparam logic [23:0] TO = 24'd10;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_SPRAY = 2;
    localparam int M_DONE  = 3;
    localparam int M_FAULT = 4;

    logic clock;
    logic reset, start, plant, spray_done;

    logic       f2, r2, l2, st2, sr2, b2, d2, fl2;
    logic [7:0] row2, col2;
    logic       f3, r3, l3, st3, sr3, b3, d3, fl3;
    logic [7:0] row3, col3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nr = 2;

    // Behavioural model: a command script plus a cycle count since motion (re)started.
    byte cmds[$];
    int  m_mode = M_IDLE;
    int  m_pos = 0;
    int  m_phase = 0;
    int  m_sw = 0;
    int  seen_right = 0;
    int  seen_left = 0;

    field_sweep_sched #(.STEP_CYCLES(SC), .ROW_LEN(RL), .NUM_ROWS(8'd2), .SPRAY_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .plant(plant), .spray_done(spray_done),
        .front(f2), .right(r2), .left(l2), .stop(st2), .spray_req(sr2), .busy(b2),
        .done(d2), .fault(fl2), .row_idx(row2), .col_idx(col2));

    field_sweep_sched #(.STEP_CYCLES(SC), .ROW_LEN(RL), .NUM_ROWS(8'd3), .SPRAY_TIMEOUT(TO)) dut_r3 (
        .clock(clock), .reset(reset), .start(start), .plant(plant), .spray_done(spray_done),
        .front(f3), .right(r3), .left(l3), .stop(st3), .spray_req(sr3), .busy(b3),
        .done(d3), .fault(fl3), .row_idx(row3), .col_idx(col3));

    logic [23:0] obs;
    assign obs = (nr == 3) ? {f3, r3, l3, st3, sr3, b3, d3, fl3, row3, col3}
                           : {f2, r2, l2, st2, sr2, b2, d2, fl2, row2, col2};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic build_cmds(input int rows);
        cmds.delete();
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < int'(RL); c++) cmds.push_back("F");
            if (r < rows - 1) cmds.push_back((r % 2 == 0) ? "R" : "L");
        end
        cmds.push_back("D");
    endtask

    // Position in the field after the first n commands of the script.
    task automatic pos_to_rc(input int n, output logic [7:0] row, output logic [7:0] col);
        int r = 0;
        int c = 0;
        for (int i = 0; i < n; i++) begin
            if (cmds[i] == "F") c++;
            else if (cmds[i] == "R" || cmds[i] == "L") begin r++; c = 0; end
        end
        row = 8'(r);
        col = 8'(c);
    endtask

    // One clock: advance the model with the current inputs, then compare after the edge.
    task automatic cycle();
        logic ef, er, el;
        logic [7:0] erow, ecol;
        logic [23:0] exp_v;
        logic [2:0] pulses;
        byte cmd;
        ef = 1'b0; er = 1'b0; el = 1'b0;
        if (reset) begin
            m_mode = M_IDLE; m_pos = 0; m_phase = 0; m_sw = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_pos = 0;
                    if (start) begin m_mode = M_RUN; m_phase = 0; end
                end
                M_RUN: begin
                    if (plant) begin
                        m_mode = M_SPRAY; m_sw = 0;
                    end else if (m_phase == int'(SC) - 1) begin
                        m_phase = 0;
                        cmd = cmds[m_pos];
                        m_pos++;
                        if (cmd == "D") m_mode = M_DONE;
                        else if (cmd == "F") ef = 1'b1;
                        else if (cmd == "R") er = 1'b1;
                        else el = 1'b1;
                    end else begin
                        m_phase++;
                    end
                end
                M_SPRAY: begin
                    if (spray_done) begin m_mode = M_RUN; m_phase = 0; end
                    else if (m_sw == int'(TO) - 1) m_mode = M_FAULT;
                    else m_sw++;
                end
                M_DONE: begin
                    if (start) begin m_mode = M_RUN; m_phase = 0; m_pos = 0; end
                end
                default: ;
            endcase
        end
        pos_to_rc(m_pos, erow, ecol);
        exp_v = {ef, er, el,
                 (m_mode == M_SPRAY) || (m_mode == M_FAULT),
                 (m_mode == M_SPRAY),
                 (m_mode == M_RUN) || (m_mode == M_SPRAY),
                 (m_mode == M_DONE),
                 (m_mode == M_FAULT),
                 erow, ecol};
        @(posedge clock);
        #1;
        cyc++;
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL outputs cyc=%0d observed %h expected %h", cyc, obs, exp_v);
        end
        pulses = obs[23:21];
        checks++;
        assert (pulses == 3'b000 || ($onehot(pulses) && !obs[20])) else begin
            errors++;
            $error("FAIL pulse_excl cyc=%0d observed %b stop %b expected onehot without stop",
                   cyc, pulses, obs[20]);
        end
        if (pulses[1]) seen_right++;
        if (pulses[0]) seen_left++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n = 0;
        while (m_mode != target && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        assert (m_mode == target) else begin
            errors++;
            $error("FAIL %s timeout observed mode %0d expected %0d", tag, m_mode, target);
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] o, input logic [7:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, o, e);
        end
    endtask

    initial begin
        int n;
        int hold;
        reset = 1'b1; start = 1'b0; plant = 1'b0; spray_done = 1'b0;
        build_cmds(2);

        // Reset state.
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Full sweep.
        pulse_start();
        run_until(M_DONE, 60, "full_sweep");
        cycle();
        check_val("sweep_done", 8'(d2), 8'd1);
        check_val("sweep_busy", 8'(b2), 8'd0);
        check_val("sweep_row", row2, 8'd1);
        check_val("sweep_col", col2, 8'd3);

        // Restart from DONE, with a start pulse during STEP that must be ignored.
        pulse_start();
        repeat (9) cycle();
        pulse_start();
        run_until(M_DONE, 60, "restart_sweep");
        cycle();

        // Plant arriving exactly on a tick cycle, spray_done three cycles later.
        pulse_start();
        n = 0;
        while (!(m_mode == M_RUN && m_phase == int'(SC) - 1 && m_pos >= 2) && n < 40) begin
            cycle();
            n++;
        end
        plant = 1'b1;
        cycle();
        plant = 1'b0;
        check_val("tick_plant_stop", 8'(st2), 8'd1);
        repeat (3) cycle();
        spray_done = 1'b1;
        cycle();
        spray_done = 1'b0;
        run_until(M_DONE, 60, "tick_plant_sweep");

        // Randomized plants and sprayer latencies.
        for (int s = 0; s < 4; s++) begin
            do_reset();
            pulse_start();
            n = 0;
            hold = 0;
            while (m_mode != M_DONE && m_mode != M_FAULT && n < 400) begin
                if (hold > 0) hold--;
                else if ($urandom_range(0, 9) == 0) hold = int'($urandom_range(1, 3));
                plant = (hold > 0);
                spray_done = ($urandom_range(0, 2) == 0);
                start = ($urandom_range(0, 15) == 0);
                cycle();
                n++;
            end
            plant = 1'b0; spray_done = 1'b0; start = 1'b0;
            cycle();
        end

        // Spray timeout into FAULT; start ignored; reset clears.
        do_reset();
        pulse_start();
        cycle();
        plant = 1'b1;
        cycle();
        plant = 1'b0;
        repeat (12) cycle();
        check_val("timeout_fault", 8'(fl2), 8'd1);
        check_val("timeout_stop", 8'(st2), 8'd1);
        pulse_start();
        repeat (3) cycle();
        check_val("fault_sticky", 8'(fl2), 8'd1);
        do_reset();
        check_val("fault_cleared", 8'(fl2), 8'd0);

        // Reset in the middle of a spray.
        pulse_start();
        repeat (5) cycle();
        plant = 1'b1;
        cycle();
        plant = 1'b0;
        cycle();
        check_val("mid_spray_req", 8'(sr2), 8'd1);
        do_reset();
        check_val("reset_spray_req", 8'(sr2), 8'd0);
        pulse_start();
        run_until(M_DONE, 60, "after_reset_sweep");

        // Three rows: right then left, and no third turn.
        nr = 3;
        build_cmds(3);
        do_reset();
        seen_right = 0;
        seen_left = 0;
        pulse_start();
        run_until(M_DONE, 80, "three_row_sweep");
        cycle();
        check_val("three_row_rights", 8'(seen_right), 8'd1);
        check_val("three_row_lefts", 8'(seen_left), 8'd1);
        check_val("three_row_final_row", row3, 8'd2);
        check_val("three_row_final_col", col3, 8'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
